// File: rtl/seq_signed_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_signed_div_pkg
// Brief    : Shared types and helpers for the iterative signed/unsigned divider
// Revision : 1.0 - initial release
// ============================================================================
package seq_signed_div_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Width of the iteration counter that walks WIDTH-1 down to 0
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage : seq_signed_div_pkg
`default_nettype wire

// File: rtl/seq_signed_div_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_signed_div_if
// Brief    : Request/result bundle between a divider client and the divider
// Revision : 1.0 - initial release
// ============================================================================
interface seq_signed_div_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   signed_mode;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_zero;
    logic                   overflow;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, quotient, remainder, div_zero, overflow
    );

endinterface : seq_signed_div_if
`default_nettype wire

// File: rtl/seq_signed_div_step.sv
`default_nettype none
// ============================================================================
// Module   : seq_signed_div_step
// Brief    : One combinational restoring-division step (shift in bit, try subtract)
// Revision : 1.0 - initial release
// ============================================================================
module seq_signed_div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_p,
    input  wire logic             i_bit,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_p,
    output logic                  o_q
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    assign w_shift = {i_p, i_bit};
    // i_p < i_divisor on entry, so a successful subtraction always fits WIDTH bits
    assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;
    assign o_q     = (w_shift >= {1'b0, i_divisor});
    assign o_p     = o_q ? w_diff : w_shift[WIDTH-1:0];

endmodule : seq_signed_div_step
`default_nettype wire

// File: rtl/seq_signed_div.sv
`default_nettype none
// ============================================================================
// Module   : seq_signed_div
// Brief    : Iterative 2W/W divider, one quotient bit per cycle, signed or unsigned
// Revision : 1.0 - initial release
// ============================================================================
module seq_signed_div
    import seq_signed_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    seq_signed_div_if.slave    bus
);

    localparam int c_CNT_W = cnt_width(WIDTH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_busy;
    logic                 w_done;

    logic [2*WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]     r_dvs;
    logic [WIDTH-1:0]     r_p;
    logic [WIDTH-1:0]     r_q;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_sgn;
    logic                 r_qneg;
    logic                 r_rneg;

    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_rem;
    logic                 r_dz;
    logic                 r_ovf;

    logic                 w_sd;
    logic                 w_sv;
    logic [2*WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]     w_dvs_mag;
    logic                 w_dvs_zero;
    logic                 w_prep_ovf;

    logic [WIDTH-1:0]     w_p_nxt;
    logic                 w_q_bit;

    logic [WIDTH-1:0]     w_q_fix;
    logic [WIDTH-1:0]     w_r_fix;
    logic                 w_fix_ovf;

    // Operand conditioning, evaluated while in PREP on the raw latched operands
    assign w_sd       = r_sgn & r_dvd[2*WIDTH-1];
    assign w_sv       = r_sgn & r_dvs[WIDTH-1];
    assign w_dvd_mag  = w_sd ? (~r_dvd + 1'b1) : r_dvd;
    assign w_dvs_mag  = w_sv ? (~r_dvs + 1'b1) : r_dvs;
    assign w_dvs_zero = (r_dvs == '0);
    assign w_prep_ovf = (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_dvs_mag);

    seq_signed_div_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_p       (r_p),
        .i_bit     (r_dvd[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_p       (w_p_nxt),
        .o_q       (w_q_bit)
    );

    // Signed magnitude may reach 2^(W-1) only when the result is negative
    assign w_q_fix   = r_qneg ? (~r_q + 1'b1) : r_q;
    assign w_r_fix   = r_rneg ? (~r_p + 1'b1) : r_p;
    assign w_fix_ovf = r_sgn & (r_qneg ? (r_q[WIDTH-1] & (|r_q[WIDTH-2:0]))
                                       : r_q[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = S_PREP;
                end
            end
            S_PREP: begin
                if (w_dvs_zero || w_prep_ovf) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_ITER;
                end
            end
            S_ITER: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_p    <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_sgn  <= 1'b0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dvd <= bus.dividend;
                        r_dvs <= bus.divisor;
                        r_sgn <= bus.signed_mode;
                    end
                end
                S_PREP: begin
                    r_dvd  <= w_dvd_mag;
                    r_dvs  <= w_dvs_mag;
                    r_p    <= w_dvd_mag[2*WIDTH-1:WIDTH];
                    r_q    <= '0;
                    r_cnt  <= c_CNT_W'(WIDTH - 1);
                    r_qneg <= w_sd ^ w_sv;
                    r_rneg <= w_sd;
                    if (w_dvs_zero) begin
                        r_quot <= '1;
                        r_rem  <= r_dvd[WIDTH-1:0];
                        r_dz   <= 1'b1;
                        r_ovf  <= 1'b0;
                    end else if (w_prep_ovf) begin
                        r_quot <= '0;
                        r_rem  <= '0;
                        r_dz   <= 1'b0;
                        r_ovf  <= 1'b1;
                    end
                end
                S_ITER: begin
                    r_p   <= w_p_nxt;
                    r_q   <= {r_q[WIDTH-2:0], w_q_bit};
                    r_dvd <= {r_dvd[2*WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_dz <= 1'b0;
                    if (w_fix_ovf) begin
                        r_quot <= '0;
                        r_rem  <= '0;
                        r_ovf  <= 1'b1;
                    end else begin
                        r_quot <= w_q_fix;
                        r_rem  <= w_r_fix;
                        r_ovf  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.div_zero  = r_dz;
    assign bus.overflow  = r_ovf;

endmodule : seq_signed_div
`default_nettype wire
